rst_ctrl: RTL and testbench

Reset controller sitting between the board/testbench reset pin and the rest of the machine. It takes the raw asynchronous active-low `rst_n`, synchronises its deassertion to `clk`, and releases two reset domains in a fixed order: peripherals/RAM first, then the core. It also accepts software and watchdog reset requests from the running system, re-entering the same sequence and recording the cause of the last reset.

---
 rtl/rst_ctrl_if.sv | 28 ++
 rtl/rst_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rst_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_ctrl_if.sv
// Request/status bundle between the reset controller and the system it resets.
// The system side issues reset requests and observes the reset outputs.
interface rst_ctrl_if;
    logic       sw_rst_req;
    logic       wdt_rst_req;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic       rst_done;
    logic [1:0] rst_cause;

    modport master (
        output sw_rst_req,
        output wdt_rst_req,
        input  periph_rst_n,
        input  core_rst_n,
        input  rst_done,
        input  rst_cause
    );

    modport slave (
        input  sw_rst_req,
        input  wdt_rst_req,
        output periph_rst_n,
        output core_rst_n,
        output rst_done,
        output rst_cause
    );
endinterface

// File: rtl/rst_ctrl.sv
// Reset controller: synchronises rst_n release, then releases peripherals and
// core in order; accepts software/watchdog requests and records the reset cause.
module rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CORE_DELAY  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rst_ctrl_if.slave  bus
);

    localparam int MAX_CNT = (HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(CORE_DELAY - 1);

    localparam logic [1:0] CAUSE_EXT = 2'd0;
    localparam logic [1:0] CAUSE_SW  = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_PERIPH_UP = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Deassertion synchroniser: stage 0 samples a constant 1.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_rst_n;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= 1'b1;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_rst_n = sync_reg[SYNC_STAGES-1];

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          skip_reg, skip_next;
    logic          periph_reg, periph_next;
    logic          core_reg, core_next;
    logic          done_reg, done_next;
    logic [1:0]    cause_reg, cause_next;
    logic          req_any;

    assign req_any = bus.sw_rst_req | bus.wdt_rst_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_SYNC;
            cnt_reg    <= '0;
            skip_reg   <= 1'b0;
            periph_reg <= 1'b0;
            core_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cause_reg  <= CAUSE_EXT;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            skip_reg   <= skip_next;
            periph_reg <= periph_next;
            core_reg   <= core_next;
            done_reg   <= done_next;
            cause_reg  <= cause_next;
        end
    end

    // A request-initiated hold spends one extra cycle with everything low
    // before the hold count starts, so skip_reg parks the counter for one edge.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        skip_next  = skip_reg;
        unique case (state_reg)
            ST_SYNC: begin
                if (sync_rst_n) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    skip_next  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (skip_reg) begin
                    skip_next = 1'b0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_PERIPH_UP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PERIPH_UP: begin
                if (cnt_reg == DELAY_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (req_any) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    skip_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_SYNC;
                cnt_next   = '0;
                skip_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        periph_next = periph_reg;
        core_next   = core_reg;
        done_next   = done_reg;
        cause_next  = cause_reg;
        unique case (state_reg)
            ST_SYNC: begin
                periph_next = 1'b0;
                core_next   = 1'b0;
                done_next   = 1'b0;
            end
            ST_HOLD: begin
                if (!skip_reg && cnt_reg == HOLD_LAST) periph_next = 1'b1;
            end
            ST_PERIPH_UP: begin
                if (cnt_reg == DELAY_LAST) begin
                    core_next = 1'b1;
                    done_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (req_any) begin
                    periph_next = 1'b0;
                    core_next   = 1'b0;
                    done_next   = 1'b0;
                    cause_next  = bus.wdt_rst_req ? CAUSE_WDT : CAUSE_SW;
                end
            end
            default: begin
                periph_next = 1'b0;
                core_next   = 1'b0;
                done_next   = 1'b0;
            end
        endcase
    end

    assign bus.periph_rst_n = periph_reg;
    assign bus.core_rst_n   = core_reg;
    assign bus.rst_done     = done_reg;
    assign bus.rst_cause    = cause_reg;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl: default instance for the sequence tests and a
// second instance with SYNC_STAGES=3, HOLD_CYCLES=1, CORE_DELAY=1.
module tb_rst_ctrl;

    logic clk = 1'b0;
    logic rst_n_a = 1'b1;
    logic rst_n_b = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    rst_ctrl_if a_if ();
    rst_ctrl_if b_if ();

    rst_ctrl dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (a_if.slave)
    );

    rst_ctrl #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .CORE_DELAY  (1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    // Core must never be out of reset while peripherals are held.
    always @(negedge clk) begin
        tests_run++;
        assert (!(a_if.core_rst_n && !a_if.periph_rst_n)) else begin
            tests_failed++;
            $display("FAIL invariant_a core=%0b periph=%0b at %0t", a_if.core_rst_n, a_if.periph_rst_n, $time);
        end
        tests_run++;
        assert (!(b_if.core_rst_n && !b_if.periph_rst_n)) else begin
            tests_failed++;
            $display("FAIL invariant_b core=%0b periph=%0b at %0t", b_if.core_rst_n, b_if.periph_rst_n, $time);
        end
    end

    task automatic test_reset();
        logic exp_p, exp_c;
        a_if.sw_rst_req  = 1'b0;
        a_if.wdt_rst_req = 1'b0;
        #1 rst_n_a = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            tests_run++;
            if ({a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause} !== 5'b0) begin
                tests_failed++;
                $display("FAIL reset_hold outs=%b required=00000", {a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause});
            end
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            exp_p = (k >= 19);
            exp_c = (k >= 23);
            tests_run++;
            if ({a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause} !== {exp_p, exp_c, exp_c, 2'd0}) begin
                tests_failed++;
                $display("FAIL power_on E%0d p/c/d/cause=%b required=%b", k,
                         {a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause}, {exp_p, exp_c, exp_c, 2'd0});
            end
        end
        $display("[TB] power-on release sequence checked");
    endtask

    // Request at edge R from RUN; checks R through R+22 for the given cause.
    task automatic test_request(input logic sw, input logic wdt, input logic [1:0] cause, input logic late_sw, input string name);
        logic exp_p, exp_c;
        a_if.sw_rst_req  = sw;
        a_if.wdt_rst_req = wdt;
        @(posedge clk); #1;
        a_if.sw_rst_req  = 1'b0;
        a_if.wdt_rst_req = 1'b0;
        tests_run++;
        if ({a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause} !== {3'b000, cause}) begin
            tests_failed++;
            $display("FAIL %s_at_R outs=%b required=%b", name, {a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause}, {3'b000, cause});
        end
        for (int j = 1; j <= 22; j++) begin
            if (late_sw && j == 3) a_if.sw_rst_req = 1'b1;
            @(posedge clk); #1;
            a_if.sw_rst_req = 1'b0;
            exp_p = (j >= 17);
            exp_c = (j >= 21);
            tests_run++;
            if ({a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause} !== {exp_p, exp_c, exp_c, cause}) begin
                tests_failed++;
                $display("FAIL %s R+%0d outs=%b required=%b", name, j,
                         {a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause}, {exp_p, exp_c, exp_c, cause});
            end
        end
        $display("[TB] request sequence %s checked", name);
    endtask

    task automatic test_sw_reset();
        test_request(1'b1, 1'b0, 2'd1, 1'b0, "sw_reset");
    endtask

    task automatic test_simultaneous();
        test_request(1'b1, 1'b1, 2'd2, 1'b0, "simultaneous");
    endtask

    task automatic test_ignored();
        test_request(1'b0, 1'b1, 2'd2, 1'b1, "ignored_in_hold");
    endtask

    task automatic test_midreset();
        logic exp_p, exp_c;
        a_if.sw_rst_req = 1'b1;
        @(posedge clk); #1;
        a_if.sw_rst_req = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if ({a_if.periph_rst_n, a_if.core_rst_n} !== 2'b10) begin
            tests_failed++;
            $display("FAIL midreset_pre p/c=%b required=10", {a_if.periph_rst_n, a_if.core_rst_n});
        end
        #2 rst_n_a = 1'b0;
        #1;
        tests_run++;
        if ({a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midreset_async outs=%b required=00000", {a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_a = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            exp_p = (k >= 19);
            exp_c = (k >= 23);
            tests_run++;
            if ({a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause} !== {exp_p, exp_c, exp_c, 2'd0}) begin
                tests_failed++;
                $display("FAIL midreset_repeat E%0d outs=%b required=%b", k,
                         {a_if.periph_rst_n, a_if.core_rst_n, a_if.rst_done, a_if.rst_cause}, {exp_p, exp_c, exp_c, 2'd0});
            end
        end
        $display("[TB] mid-sequence external reset checked");
    endtask

    task automatic test_sweep();
        logic exp_p, exp_c;
        b_if.sw_rst_req  = 1'b0;
        b_if.wdt_rst_req = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_p = (k >= 5);
            exp_c = (k >= 6);
            tests_run++;
            if ({b_if.periph_rst_n, b_if.core_rst_n, b_if.rst_done, b_if.rst_cause} !== {exp_p, exp_c, exp_c, 2'd0}) begin
                tests_failed++;
                $display("FAIL sweep_power_on E%0d outs=%b required=%b", k,
                         {b_if.periph_rst_n, b_if.core_rst_n, b_if.rst_done, b_if.rst_cause}, {exp_p, exp_c, exp_c, 2'd0});
            end
        end
        b_if.wdt_rst_req = 1'b1;
        @(posedge clk); #1;
        b_if.wdt_rst_req = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            exp_p = (j >= 2);
            exp_c = (j >= 3);
            tests_run++;
            if ({b_if.periph_rst_n, b_if.core_rst_n, b_if.rst_done, b_if.rst_cause} !== {exp_p, exp_c, exp_c, 2'd2}) begin
                tests_failed++;
                $display("FAIL sweep_wdt R+%0d outs=%b required=%b", j,
                         {b_if.periph_rst_n, b_if.core_rst_n, b_if.rst_done, b_if.rst_cause}, {exp_p, exp_c, exp_c, 2'd2});
            end
        end
        $display("[TB] parameter sweep instance checked");
    endtask

    initial begin
        b_if.sw_rst_req  = 1'b0;
        b_if.wdt_rst_req = 1'b0;
        #1 rst_n_b = 1'b0;
        test_reset();
        test_sw_reset();
        test_simultaneous();
        test_ignored();
        test_midreset();
        test_sweep();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
